cpu_if_queue: RTL

Parametrised instruction-fetch stage with a decoupling instruction queue between the I-cache and the decoder. Each cycle it fetches at most one 32-bit instruction and byte-swaps it into RISC-V order. JAL targets are followed statically; fetch halts after JALR or a conditional branch until the backend resolves the next PC. A backend redirect flushes the queue and restarts fetch. Replaces the single-slot fetch register and turns the decoder interface into a ready/valid handshake.

---
 rtl/cpu_if_queue.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cpu_if_queue.sv
// cpu_if_queue
// Instruction-fetch stage with a small decoupling queue between the I-cache
// and the decoder. Fetches at most one word per cycle, byte-swaps it into
// RISC-V order, follows JAL statically, and halts after JALR/branches until
// the backend resolves the next PC. A resolve flushes the queue.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   rdy            global enable; low freezes every register
//   req_valid      fetch request to the I-cache
//   req_addr       fetch address (the pc register)
//   hit, inst      same-cycle I-cache response (inst in memory byte order)
//   resolve_valid  backend redirect; resolve_addr is the new PC
//   out_valid      queue head valid to decoder; out_ready accepts it
//   out_pc         PC of the head instruction
//   out_inst       head instruction in RISC-V order
//   stalled        fetch is waiting for a resolve
module cpu_if_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              hit,
    input  logic [31:0]       inst,
    input  logic              resolve_valid,
    input  logic [ADDR_W-1:0] resolve_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_inst,
    output logic              stalled
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] q_pc   [QDEPTH];
    logic [31:0]       q_inst [QDEPTH];

    logic [31:0]       sw;
    logic [6:0]        opc;
    logic [20:0]       jimm;
    logic [ADDR_W-1:0] jal_off;
    logic              is_jal;
    logic              is_halt;
    logic [ADDR_W-1:0] pc_next;
    logic              enq;
    logic              deq;

    always_comb begin
        sw      = {inst[7:0], inst[15:8], inst[23:16], inst[31:24]};
        opc     = sw[6:0];
        jimm    = {sw[31], sw[19:12], sw[20], sw[30:21], 1'b0};
        // Sign-extending size cast; wraps naturally modulo 2^ADDR_W on add.
        jal_off = ADDR_W'($signed(jimm));
        is_jal  = (opc == 7'b1101111);
        is_halt = ((opc == 7'b1100111) && (sw[14:12] == 3'b000)) ||
                  (opc == 7'b1100011);
        pc_next = is_jal ? (pc + jal_off) : (pc + ADDR_W'(4));
    end

    assign req_valid = rdy & ~rst & (state == ST_RUN) & (count != FULL_CNT) & ~resolve_valid;
    assign out_valid = rdy & ~rst & (count != '0) & ~resolve_valid;
    assign req_addr  = pc;
    assign out_pc    = q_pc[head];
    assign out_inst  = q_inst[head];
    assign stalled   = (state == ST_WAIT);

    // Both strobes already exclude rst, !rdy and resolve cycles.
    assign enq = req_valid & hit;
    assign deq = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (resolve_valid) begin
                state <= ST_RUN;
                pc    <= resolve_addr & ~ADDR_W'(3);
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq) begin
                    tail <= tail + 1'b1;
                    pc   <= pc_next;
                    if (is_halt) begin
                        state <= ST_WAIT;
                    end
                end
                if (deq) begin
                    head <= head + 1'b1;
                end
                case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[tail]   <= pc;
            q_inst[tail] <= sw;
        end
    end

endmodule
